// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the MEM pipeline stage.
//   state_t      - MEM stage FSM states (IDLE / REQ / WAIT)
//   acc_size_t   - memory access size (byte / half / word)
//   OP3_*        - SPARC op3 encodings of the supported load/store forms
//   decode_mem() - op3 -> {recognised, size, signed, store}
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  localparam logic [1:0] OP_MEM    = 2'b11;

  localparam logic [5:0] OP3_LD    = 6'b000000;
  localparam logic [5:0] OP3_LDUB  = 6'b000001;
  localparam logic [5:0] OP3_LDUH  = 6'b000010;
  localparam logic [5:0] OP3_ST    = 6'b000100;
  localparam logic [5:0] OP3_STB   = 6'b000101;
  localparam logic [5:0] OP3_STH   = 6'b000110;
  localparam logic [5:0] OP3_LDSB  = 6'b001001;
  localparam logic [5:0] OP3_LDSH  = 6'b001010;

  typedef struct packed {
    logic      valid;
    acc_size_t size;
    logic      sign;
    logic      store;
  } mem_dec_t;

  function automatic mem_dec_t decode_mem(input logic [5:0] op3);
    mem_dec_t d;
    d.valid = 1'b1;
    d.size  = SZ_WORD;
    d.sign  = 1'b0;
    d.store = 1'b0;
    case (op3)
      OP3_LD:   ;
      OP3_LDUB: d.size = SZ_BYTE;
      OP3_LDUH: d.size = SZ_HALF;
      OP3_ST:   d.store = 1'b1;
      OP3_STB: begin
        d.size  = SZ_BYTE;
        d.store = 1'b1;
      end
      OP3_STH: begin
        d.size  = SZ_HALF;
        d.store = 1'b1;
      end
      OP3_LDSB: begin
        d.size = SZ_BYTE;
        d.sign = 1'b1;
      end
      OP3_LDSH: begin
        d.size = SZ_HALF;
        d.sign = 1'b1;
      end
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational big-endian byte-lane handling.
//   Store side: i_st_size/i_st_off/i_st_data -> o_be (bit3 = MSB lane) and
//               o_wdata (store value replicated across all lanes).
//   Load side:  i_ld_size/i_ld_off/i_ld_sign/i_rdata -> o_ld_data, the
//               addressed byte/half/word, sign- or zero-extended.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  acc_size_t         i_st_size,
  input  logic [1:0]        i_st_off,
  input  logic [DATA_W-1:0] i_st_data,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  input  acc_size_t         i_ld_size,
  input  logic [1:0]        i_ld_off,
  input  logic              i_ld_sign,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [31:0] w_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be  = 4'b0000;
    w_rep = '0;
    case (i_st_size)
      SZ_BYTE: begin
        o_be  = 4'b1000 >> i_st_off;
        w_rep = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_be  = i_st_off[1] ? 4'b0011 : 4'b1100;
        w_rep = {2{i_st_data[15:0]}};
      end
      default: begin
        o_be  = 4'b1111;
        w_rep = i_st_data[31:0];
      end
    endcase
    o_wdata       = '0;
    o_wdata[31:0] = w_rep;
  end

  // Lane 0 (offset 0) is the most significant byte of the word.
  always_comb begin
    w_byte = 8'h00;
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_off[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_ld_data = '0;
    case (i_ld_size)
      SZ_BYTE: begin
        o_ld_data       = {DATA_W{i_ld_sign & w_byte[7]}};
        o_ld_data[7:0]  = w_byte;
      end
      SZ_HALF: begin
        o_ld_data       = {DATA_W{i_ld_sign & w_half[15]}};
        o_ld_data[15:0] = w_half;
      end
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: SPARC MEM pipeline stage.
//   clk/reset         - clock, synchronous active-high reset
//   in_*              - EX/MEM bundle; in_stall holds it upstream
//   dmem_req_*        - data memory request (valid/ready handshake),
//                       word-aligned address, byte enables, lane data
//   dmem_rsp_*        - one response per request, latency >= 1 cycle
//   out_*             - registered MEM/WB bundle; out_valid pulses once
//                       per accepted instruction
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int TARGET_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_stall,
  input  logic [TARGET_W-1:0] in_target,
  input  logic [4:0]          in_regD,
  input  logic [DATA_W-1:0]   in_alures,
  input  logic [1:0]          in_op,
  input  logic [2:0]          in_op2,
  input  logic [5:0]          in_op3,
  input  logic [DATA_W-1:0]   in_st_data,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic                dmem_we,
  output logic [3:0]          dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_rsp_valid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                out_valid,
  output logic [4:0]          out_regD,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_wb_en,
  output logic                out_trap,
  output logic [TARGET_W-1:0] out_target
);

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_addr;
  logic [1:0]          r_off;
  acc_size_t           r_size;
  logic                r_sign;
  logic                r_we;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [4:0]          r_regD;
  logic [TARGET_W-1:0] r_target;

  mem_dec_t            w_dec;
  logic                w_mem_ok;
  logic                w_bad_op;
  logic                w_misalign;
  logic                w_start;
  logic                w_idle_done;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_ld_data;
  logic                w_unused;

  // op2 only matters for non-memory formats handled upstream.
  assign w_unused = ^in_op2;

  assign w_dec      = decode_mem(in_op3);
  assign w_mem_ok   = (in_op == OP_MEM) && w_dec.valid;
  assign w_bad_op   = (in_op == OP_MEM) && !w_dec.valid;
  assign w_misalign = w_mem_ok &&
                      (((w_dec.size == SZ_HALF) && in_alures[0]) ||
                       ((w_dec.size == SZ_WORD) && (in_alures[1:0] != 2'b00)));
  assign w_start    = (r_state == ST_IDLE) && in_valid && w_mem_ok && !w_misalign;
  // Non-memory ops, illegal op3 and misaligned accesses all retire from IDLE.
  assign w_idle_done = (r_state == ST_IDLE) && in_valid && !w_start;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .i_st_size (w_dec.size),
    .i_st_off  (in_alures[1:0]),
    .i_st_data (in_st_data),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .i_ld_size (r_size),
    .i_ld_off  (r_off),
    .i_ld_sign (r_sign),
    .i_rdata   (dmem_rdata),
    .o_ld_data (w_ld_data)
  );

  always_comb begin
    w_next         = r_state;
    in_stall       = 1'b0;
    dmem_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          in_stall = 1'b1;
          w_next   = ST_REQ;
        end
      end
      ST_REQ: begin
        in_stall       = 1'b1;
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Release upstream in the response cycle so the next instruction
        // arrives exactly as this one retires.
        in_stall = !dmem_rsp_valid;
        if (dmem_rsp_valid) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign dmem_addr  = r_addr;
  assign dmem_we    = (r_state == ST_REQ) && r_we;
  assign dmem_be    = (r_state == ST_REQ) ? r_be : 4'b0000;
  assign dmem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_off      <= '0;
      r_size     <= SZ_BYTE;
      r_sign     <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_regD     <= '0;
      r_target   <= '0;
      out_valid  <= 1'b0;
      out_regD   <= '0;
      out_result <= '0;
      out_wb_en  <= 1'b0;
      out_trap   <= 1'b0;
      out_target <= '0;
    end else begin
      r_state   <= w_next;
      out_valid <= 1'b0;
      out_wb_en <= 1'b0;
      out_trap  <= 1'b0;

      if (w_start) begin
        r_addr   <= {in_alures[DATA_W-1:2], 2'b00};
        r_off    <= in_alures[1:0];
        r_size   <= w_dec.size;
        r_sign   <= w_dec.sign;
        r_we     <= w_dec.store;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_regD   <= in_regD;
        r_target <= in_target;
      end

      if (w_idle_done) begin
        out_valid  <= 1'b1;
        out_regD   <= in_regD;
        out_target <= in_target;
        out_result <= in_alures;
        if (w_bad_op || w_misalign) begin
          out_trap <= 1'b1;
        end else begin
          out_wb_en <= (in_regD != 5'd0);
        end
      end

      if ((r_state == ST_WAIT) && dmem_rsp_valid) begin
        out_valid  <= 1'b1;
        out_regD   <= r_regD;
        out_target <= r_target;
        if (r_we) begin
          out_result <= '0;
        end else begin
          out_result <= w_ld_data;
          out_wb_en  <= (r_regD != 5'd0);
        end
      end
    end
  end

endmodule
